ddr_access_arbiter: RTL and testbench

//   Shares the single DDR AXI read/write path between NUM_CLIENTS requesters, each a layer-level memory user.

---
 rtl/ddr_access_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ddr_access_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_access_arbiter.sv
// Round-robin arbiter sharing one DDR AXI read/write level handshake between NUM_CLIENTS requesters.
// A watchdog aborts a transfer that never sees its done. A low gap is always inserted between transfers.
module ddr_access_arbiter #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            cl_req,
    input  logic [NUM_CLIENTS-1:0]            cl_we,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
    output logic [NUM_CLIENTS-1:0]            cl_gnt,
    output logic [NUM_CLIENTS-1:0]            cl_done,
    output logic                              uip2axi_rd_en,
    output logic [ADDR_WIDTH-1:0]             uip2axi_rd_addr,
    input  logic                              axi2uip_rd_done,
    output logic                              uip2axi_wr_en,
    output logic [ADDR_WIDTH-1:0]             uip2axi_wr_addr,
    input  logic                              axi2uip_wr_done,
    output logic                              busy,
    output logic                              timeout_err,
    input  logic                              err_clr
);
    localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic                    we_q, we_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CLIENTS-1:0]  gnt_q, gnt_d;
    logic [NUM_CLIENTS-1:0]  done_q, done_d;
    logic                    rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic                    found;
    logic [IDX_W-1:0]        cand;
    logic [IDX_W-1:0]        pick_idx;
    logic [ADDR_WIDTH-1:0]   pick_addr;
    logic                    done_hit;
    logic                    to_hit;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        rd_en_d   = rd_en_q;
        wr_en_d   = wr_en_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        err_d     = err_clr ? 1'b0 : err_q;
        found     = 1'b0;
        cand      = '0;
        pick_idx  = '0;

        // First requester after the last winner, wrapping around.
        for (int i = 1; i <= int'(NUM_CLIENTS); i++) begin
            cand = IDX_W'((int'(last_q) + i) % int'(NUM_CLIENTS));
            if (!found && cl_req[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
        pick_addr = cl_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];

        done_hit = we_q ? axi2uip_wr_done : axi2uip_rd_done;
        to_hit   = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d         = S_WAIT;
                    idx_d           = pick_idx;
                    we_d            = cl_we[pick_idx];
                    cnt_d           = '0;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    if (cl_we[pick_idx]) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = pick_addr;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = pick_addr;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done_hit || to_hit) begin
                    state_d       = S_GAP;
                    rd_en_d       = 1'b0;
                    wr_en_d       = 1'b0;
                    gnt_d         = '0;
                    done_d[idx_q] = 1'b1;
                    last_d        = idx_q;
                    if (!done_hit) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            last_q    <= IDX_W'(NUM_CLIENTS - 1);
            we_q      <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign cl_gnt          = gnt_q;
    assign cl_done         = done_q;
    assign uip2axi_rd_en   = rd_en_q;
    assign uip2axi_wr_en   = wr_en_q;
    assign uip2axi_rd_addr = rd_addr_q;
    assign uip2axi_wr_addr = wr_addr_q;
    assign busy            = busy_q;
    assign timeout_err     = err_q;
endmodule

// File: tb/tb_ddr_access_arbiter.sv
// Directed bench for ddr_access_arbiter: single read, round robin, direction filter, watchdog, reset abort.
module tb_ddr_access_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  cl_req;
    logic [N-1:0]  cl_we;
    logic [N*AW-1:0] cl_addr;
    logic [N-1:0]  cl_gnt;
    logic [N-1:0]  cl_done;
    logic          rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          rd_done, wr_done;
    logic          busy, timeout_err, err_clr;

    int total = 0;
    int bad   = 0;
    int low;
    int n;

    ddr_access_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr),
        .cl_gnt(cl_gnt), .cl_done(cl_done),
        .uip2axi_rd_en(rd_en), .uip2axi_rd_addr(rd_addr), .axi2uip_rd_done(rd_done),
        .uip2axi_wr_en(wr_en), .uip2axi_wr_addr(wr_addr), .axi2uip_wr_done(wr_done),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count low-en samples until an enable shows up, bounded.
    task automatic wait_en(output int lowc);
        int k;
        k = 0;
        while (!(rd_en || wr_en) && k < 20) begin
            tick();
            k++;
        end
        lowc = k;
        chk("en_seen", 64'(rd_en | wr_en), 64'd1);
    endtask

    initial begin
        rst = 1'b1; cl_req = '0; cl_we = '0; cl_addr = '0;
        rd_done = 1'b0; wr_done = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_gnt",  64'(cl_gnt), 64'h0);
        chk("rst_done", 64'(cl_done), 64'h0);
        chk("rst_en",   64'({rd_en, wr_en}), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err",  64'(timeout_err), 64'h0);
        rst = 1'b0;
        tick();

        // 1. Single read from client 0.
        cl_req = 4'b0001; cl_we = 4'b0000; cl_addr[0*AW +: AW] = 32'h0000_1000;
        tick();
        chk("t1_rd_en",   64'(rd_en), 64'd1);
        chk("t1_wr_en",   64'(wr_en), 64'd0);
        chk("t1_rd_addr", 64'(rd_addr), 64'h1000);
        chk("t1_gnt",     64'(cl_gnt), 64'h1);
        chk("t1_busy",    64'(busy), 64'd1);
        tick(); tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0; cl_req = '0;
        chk("t1_en_drop", 64'(rd_en), 64'd0);
        chk("t1_done",    64'(cl_done), 64'h1);
        chk("t1_gnt_gap", 64'(cl_gnt), 64'h0);
        tick();
        chk("t1_done_1cyc", 64'(cl_done), 64'h0);
        tick();
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // 2. Round robin with all four reading; restart from reset so client 0 leads.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 4; c++) cl_addr[c*AW +: AW] = 32'h0000_0100 * (c + 1);
        cl_we = '0; cl_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_en(low);
            chk($sformatf("t2_gnt%0d", g), 64'(cl_gnt), 64'(1 << (g % 4)));
            chk($sformatf("t2_addr%0d", g), 64'(rd_addr), 64'(32'h100 * ((g % 4) + 1)));
            if (g > 0) chk($sformatf("t2_gap%0d", g), 64'(low), 64'd2);
            repeat (4) tick();
            rd_done = 1'b1;
            tick();
            rd_done = 1'b0;
            if (g == 4) cl_req = '0;
            chk($sformatf("t2_done%0d", g), 64'(cl_done), 64'(1 << (g % 4)));
        end
        tick(); tick();

        // 3. Client 2 write; opposite-direction done and input changes are ignored.
        cl_req = 4'b0100; cl_we = 4'b0100; cl_addr[2*AW +: AW] = 32'h0000_2000;
        wait_en(low);
        chk("t3_gnt",   64'(cl_gnt), 64'h4);
        chk("t3_wr_en", 64'(wr_en), 64'd1);
        chk("t3_rd_en", 64'(rd_en), 64'd0);
        chk("t3_waddr", 64'(wr_addr), 64'h2000);
        cl_addr[2*AW +: AW] = 32'hDEAD_BEEF; cl_we = '0;
        tick(); tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("t3_ign_wr_en", 64'(wr_en), 64'd1);
        chk("t3_ign_done",  64'(cl_done), 64'h0);
        chk("t3_hold_addr", 64'(wr_addr), 64'h2000);
        tick();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0; cl_req = '0;
        chk("t3_wr_drop",  64'(wr_en), 64'd0);
        chk("t3_done",     64'(cl_done), 64'h4);
        chk("t3_rd_hold",  64'(rd_addr), 64'h100);
        chk("t3_no_err",   64'(timeout_err), 64'd0);
        tick(); tick();

        // 4. Watchdog: client 0 read never completes.
        cl_req = 4'b0001; cl_we = '0;
        wait_en(low);
        cl_req = '0;
        chk("t4_gnt", 64'(cl_gnt), 64'h1);
        n = 0;
        while (rd_en && n < 40) begin
            n++;
            tick();
        end
        chk("t4_wait_cycles", 64'(n), 64'd16);
        chk("t4_done",        64'(cl_done), 64'h1);
        chk("t4_err",         64'(timeout_err), 64'd1);
        tick(); tick();
        chk("t4_err_sticky", 64'(timeout_err), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_err_clr", 64'(timeout_err), 64'd0);

        // 5. Done lands on the last watchdog cycle: done wins.
        cl_req = 4'b0010; cl_we = '0;
        wait_en(low);
        cl_req = '0;
        chk("t5_gnt", 64'(cl_gnt), 64'h2);
        repeat (15) tick();
        chk("t5_still_en", 64'(rd_en), 64'd1);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("t5_en_drop", 64'(rd_en), 64'd0);
        chk("t5_done",    64'(cl_done), 64'h2);
        chk("t5_no_err",  64'(timeout_err), 64'd0);
        tick(); tick();

        // 6. Reset during client 1 WAIT; pointer returns to client 0 priority.
        cl_req = 4'b0010; cl_we = 4'b0010; cl_addr[1*AW +: AW] = 32'h0000_3000;
        wait_en(low);
        chk("t6_gnt",   64'(cl_gnt), 64'h2);
        chk("t6_wr_en", 64'(wr_en), 64'd1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_en",    64'({rd_en, wr_en}), 64'h0);
        chk("t6_rst_gnt",   64'(cl_gnt), 64'h0);
        chk("t6_rst_done",  64'(cl_done), 64'h0);
        chk("t6_rst_busy",  64'(busy), 64'd0);
        chk("t6_rst_waddr", 64'(wr_addr), 64'h0);
        cl_req = 4'b0011; cl_we = 4'b0000;
        wait_en(low);
        chk("t6_regnt", 64'(cl_gnt), 64'h1);
        chk("t6_rd_addr", 64'(rd_addr), 64'h100);
        cl_req = '0;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("t6_done", 64'(cl_done), 64'h1);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
